// File: rtl/pipe_pkg.sv
// Shared pipeline-control types and constants for the hazard/sequencing logic.
package pipe_pkg;

  typedef enum logic [1:0] {RUN, MD_BUSY, EXC, ERET} hz_state_t;

  localparam logic [4:0]  EXC_RI  = 5'd10;
  localparam logic [4:0]  EXC_OV  = 5'd12;
  localparam logic [4:0]  EXC_DZ  = 5'd13;
  localparam logic [4:0]  EXC_SYS = 5'd8;
  localparam logic [4:0]  EXC_BP  = 5'd9;

  localparam logic [31:0] EXC_VECTOR_DEFAULT = 32'h0000_F000;
  localparam int          CNT_W              = 6;

  // Break is the lowest priority, so it is implied when nothing else is set.
  function automatic logic [4:0] exc_prio(input logic ri, input logic ov,
                                          input logic dz, input logic sys);
    if (ri)       return EXC_RI;
    else if (ov)  return EXC_OV;
    else if (dz)  return EXC_DZ;
    else if (sys) return EXC_SYS;
    else          return EXC_BP;
  endfunction

endpackage

// File: rtl/md_busy_counter.sv
// Loadable down-counter tracking the remaining busy cycles of the HI/LO unit.
module md_busy_counter
  import pipe_pkg::*;
#(
  parameter int W = CNT_W
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         load,
  input  logic         abort,
  input  logic         dec,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] cnt,
  output logic         zero
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (abort)                    cnt_d = '0;
    else if (load)                cnt_d = load_val;
    else if (dec && cnt_q != '0)  cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign cnt  = cnt_q;
  assign zero = (cnt_q == '0);

endmodule

// File: rtl/hazard_ctrl.sv
// Stall/flush sequencer: load-use bubbles, mult/div busy holds, and
// exception / eret recovery with PC redirect.
module hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int          MUL_LAT    = 4,
  parameter int          DIV_LAT    = 32,
  parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEFAULT
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [4:0]  ID_rs,
  input  logic [4:0]  ID_rt,
  input  logic        ID_use_rs,
  input  logic        ID_use_rt,
  input  logic        ID_hilo_use,
  input  logic        ID_EX_MemIOtoReg,
  input  logic [4:0]  ID_EX_waddr,
  input  logic        EX_md_start,
  input  logic        EX_md_is_div,
  input  logic        WB_Overflow,
  input  logic        WB_Divide_zero,
  input  logic        WB_Syscall,
  input  logic        WB_Break,
  input  logic        WB_Reserved_instruction,
  input  logic        WB_Eret,
  input  logic [31:0] WB_PC,
  input  logic [31:0] cp0_epc,
  output logic        pc_stall,
  output logic        IF_ID_stall,
  output logic        ID_EX_flush,
  output logic        IF_ID_flush,
  output logic        EX_MEM_flush,
  output logic        MEM_WB_flush,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic        cp0_exc_we,
  output logic [4:0]  exc_code,
  output logic [31:0] epc_value,
  output logic        md_busy
);

  hz_state_t        state_q, state_d;
  logic             flush_q, flush_d;
  logic             exc_we_q, exc_we_d;
  logic [4:0]       exc_code_q, exc_code_d;
  logic [31:0]      epc_q, epc_d;
  logic [31:0]      rpc_q, rpc_d;
  logic             cnt_load, cnt_abort, cnt_dec, cnt_zero;
  logic [CNT_W-1:0] cnt_val, cnt;
  logic             exc_any, md_go, front_en, load_use, hilo_hold, hold;

  assign exc_any = WB_Overflow | WB_Divide_zero | WB_Syscall | WB_Break |
                   WB_Reserved_instruction;
  assign md_go   = EX_md_start & ~(EX_md_is_div & WB_Divide_zero);
  assign cnt_dec = (state_q == MD_BUSY);

  md_busy_counter #(.W(CNT_W)) u_cnt (
    .clock    (clock),
    .reset    (reset),
    .load     (cnt_load),
    .abort    (cnt_abort),
    .dec      (cnt_dec),
    .load_val (cnt_val),
    .cnt      (cnt),
    .zero     (cnt_zero)
  );

  always_comb begin
    state_d    = state_q;
    flush_d    = 1'b0;
    exc_we_d   = 1'b0;
    exc_code_d = exc_code_q;
    epc_d      = epc_q;
    rpc_d      = rpc_q;
    cnt_load   = 1'b0;
    cnt_abort  = 1'b0;
    cnt_val    = EX_md_is_div ? CNT_W'(DIV_LAT - 1) : CNT_W'(MUL_LAT - 1);
    case (state_q)
      RUN, MD_BUSY: begin
        if (exc_any) begin
          state_d    = EXC;
          cnt_abort  = 1'b1;
          flush_d    = 1'b1;
          exc_we_d   = 1'b1;
          exc_code_d = exc_prio(WB_Reserved_instruction, WB_Overflow,
                                WB_Divide_zero, WB_Syscall);
          epc_d      = WB_PC;
          rpc_d      = EXC_VECTOR;
        end else if (WB_Eret) begin
          state_d   = ERET;
          cnt_abort = 1'b1;
          flush_d   = 1'b1;
          rpc_d     = cp0_epc;
        end else if (md_go) begin
          state_d  = MD_BUSY;
          cnt_load = 1'b1;
        end else if (state_q == MD_BUSY && cnt_zero) begin
          state_d = RUN;
        end
      end
      // Recovery cycles: anything in flight belongs to flushed instructions.
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= RUN;
      flush_q    <= 1'b0;
      exc_we_q   <= 1'b0;
      exc_code_q <= '0;
      epc_q      <= '0;
      rpc_q      <= '0;
    end else begin
      state_q    <= state_d;
      flush_q    <= flush_d;
      exc_we_q   <= exc_we_d;
      exc_code_q <= exc_code_d;
      epc_q      <= epc_d;
      rpc_q      <= rpc_d;
    end
  end

  // Stalls are combinational but forced low while reset is held.
  assign front_en  = reset & ((state_q == RUN) | (state_q == MD_BUSY));
  assign load_use  = ID_EX_MemIOtoReg & (ID_EX_waddr != 5'd0) &
                     ((ID_use_rs & (ID_rs == ID_EX_waddr)) |
                      (ID_use_rt & (ID_rt == ID_EX_waddr)));
  assign hilo_hold = (state_q == MD_BUSY) & ID_hilo_use;
  assign hold      = front_en & (load_use | hilo_hold);

  assign md_busy        = (state_q == MD_BUSY);
  assign pc_stall       = hold;
  assign IF_ID_stall    = hold;
  assign ID_EX_flush    = hold | flush_q;
  assign IF_ID_flush    = flush_q;
  assign EX_MEM_flush   = flush_q;
  assign MEM_WB_flush   = flush_q;
  assign redirect_valid = flush_q;
  assign redirect_pc    = rpc_q;
  assign cp0_exc_we     = exc_we_q;
  assign exc_code       = exc_code_q;
  assign epc_value      = epc_q;

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline sequencing controller for the five-stage core. It owns all stall and flush decisions: it inserts load-use bubbles and holds the front end while the multi-cycle HI/LO mult/div unit is busy. It also sequences the exception and `eret` recovery reported by the WB-stage flags of the MEM/WB register, flushing every pipeline register and redirecting the PC. It sits beside the stage registers and drives their `flush` inputs and the stall enables of PC, IF/ID and ID/EX.

## Interface
Parameters:
- `MUL_LAT`, 4: mult busy cycles.
- `DIV_LAT`, 32: div busy cycles.
- `EXC_VECTOR`, 32'h0000_F000: exception handler entry address.

Ports:
- `clock` in 1: system clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-low.
- `ID_rs`, `ID_rt` in 5: source register numbers of the instruction in ID.
- `ID_use_rs`, `ID_use_rt` in 1: the ID instruction reads that source.
- `ID_hilo_use` in 1: ID instruction is mfhi/mflo/mthi/mtlo/mult/div.
- `ID_EX_MemIOtoReg` in 1: the EX instruction is a load.
- `ID_EX_waddr` in 5: destination register of the EX instruction.
- `EX_md_start` in 1: mult/div enters EX this cycle.
- `EX_md_is_div` in 1: qualifies `EX_md_start`; 1 = div.
- `WB_Overflow`, `WB_Divide_zero`, `WB_Syscall`, `WB_Break`, `WB_Reserved_instruction`, `WB_Eret` in 1 each: WB-stage flags.
- `WB_PC` in 32: PC of the WB instruction.
- `cp0_epc` in 32: current EPC.
- `pc_stall`, `IF_ID_stall` out 1: hold the PC and IF/ID.
- `ID_EX_flush`, `IF_ID_flush`, `EX_MEM_flush`, `MEM_WB_flush` out 1: stage flushes.
- `redirect_valid` out 1: load `redirect_pc` into the PC.
- `redirect_pc` out 32: redirect target.
- `cp0_exc_we` out 1: write Cause and EPC.
- `exc_code` out 5: Cause.ExcCode.
- `epc_value` out 32: EPC to write.
- `md_busy` out 1: mult/div in progress.

## Operation
State machine states: `RUN`, `MD_BUSY`, `EXC`, `ERET`.

- **Load-use** (combinational, in `RUN`/`MD_BUSY`):
  - Condition: `ID_EX_MemIOtoReg` and `ID_EX_waddr != 0` and ((`ID_use_rs` and `ID_rs == ID_EX_waddr`) or (`ID_use_rt` and `ID_rt == ID_EX_waddr`)).
  - Response: `pc_stall = IF_ID_stall = ID_EX_flush = 1` for that cycle.
- **Mult/div:**
  - `EX_md_start` loads `cnt` with `DIV_LAT-1` or `MUL_LAT-1` and moves to `MD_BUSY`.
  - `EX_md_start` with `EX_md_is_div` and `WB_Divide_zero` pending is ignored; no busy state is entered.
  - In `MD_BUSY`, `cnt` decrements each cycle; when `cnt == 0` the block returns to `RUN`.
  - `md_busy = (state == MD_BUSY)`.
  - While `md_busy` and `ID_hilo_use`: `pc_stall = IF_ID_stall = ID_EX_flush = 1`.
- **Exception:**
  - Trigger: any of Overflow / Divide_zero / Syscall / Break / Reserved_instruction in `RUN` or `MD_BUSY`.
  - The block registers `exc_code` and `epc_value = WB_PC`, aborts `cnt` to 0, and moves to `EXC`.
  - ExcCode priority: Reserved_instruction 10 > Overflow 12 > Divide_zero 13 > Syscall 8 > Break 9.
- **`EXC` (one cycle):**
  - All four flushes = 1, `cp0_exc_we = 1`, `redirect_valid = 1`, `redirect_pc = EXC_VECTOR`.
  - Next state: `RUN`.
- **Eret:**
  - `WB_Eret` (with no exception flag set) moves to `ERET`.
  - `ERET` (one cycle): all four flushes = 1, `redirect_valid = 1`, `redirect_pc = cp0_epc` sampled on entry. Next state: `RUN`.
- **Priority:** exception > eret > mult/div stall > load-use.
  - In `EXC`/`ERET`, `pc_stall` and `IF_ID_stall` are 0.
  - WB flags arriving during `EXC`/`ERET` are ignored; they belong to flushed instructions.
- **Reset** (asynchronous, any state):
  - `state = RUN`, `cnt = 0`.
  - `exc_code = 0`, `epc_value = 0`, `redirect_pc = 0`.
  - Every output 0.

## Timing
- Load-use and hilo stalls are combinational from inputs in the same cycle.
- Exception latency: flag sampled at edge k → flush, redirect and `cp0_exc_we` high for exactly the cycle after edge k. Back in `RUN` after edge k+1.
- Busy window: `md_busy` is high for exactly `DIV_LAT` (or `MUL_LAT`) cycles, starting the cycle after the start edge.
- Back-to-back mult/div: `EX_md_start` in the last busy cycle (`cnt == 0`) reloads `cnt` and stays in `MD_BUSY` with no gap.
- Flushes and `redirect_valid` are registered state decodes. They are glitch-free toward the stage registers' asynchronous flush inputs.
- Reset deasserted mid-operation → `RUN`; no pending mult/div survives reset.

## Structure
- Shared package `pipe_pkg`:
  - state enum `hz_state_t` (`RUN`, `MD_BUSY`, `EXC`, `ERET`);
  - ExcCode constants `EXC_RI = 10`, `EXC_OV = 12`, `EXC_DZ = 13`, `EXC_SYS = 8`, `EXC_BP = 9`;
  - default `EXC_VECTOR`.
- One sub-module, `md_busy_counter`: loadable down-counter with `load`, `abort` and `zero` outputs, 6 bits wide.

## Test plan
- Load `$5` in EX, `add $6,$5,$1` in ID → one cycle of `pc_stall = IF_ID_stall = ID_EX_flush = 1`, then 0. With `ID_EX_waddr = 0` → no stall.
- `div` start, mfhi in ID every cycle → `md_busy` high 32 cycles, stall high 32 cycles, both drop on the 33rd.
- `mult` busy (cnt = 2), `WB_Overflow` = 1 → next cycle all flushes = 1, `redirect_pc = 32'h0000_F000`, `exc_code = 12`, `epc_value = WB_PC`, `md_busy = 0`; then `RUN`.
- `WB_Reserved_instruction` and `WB_Syscall` together → `exc_code = 10`.
- `WB_Eret` with `cp0_epc = 32'h0000_0040` → one cycle of flushes, `redirect_pc = 32'h0000_0040`, `cp0_exc_we = 0`.
- `reset` low during `MD_BUSY` and during `EXC` → all outputs 0 immediately; state `RUN` after release.
